latch_sr: RTL and testbench
===========================

// Module: latch_sr
// PURPOSE
// - Clocked set/reset storage element: WIDTH independent bits, each set by S, cleared by R, held otherwise.
// - Used in the control path (microwave controller) to remember events such as door-open and start-request
//   until they are explicitly cleared.
// - Fully synchronous replacement for a cross-coupled gate latch; no combinational loops.
// PARAMETERS
// - WIDTH     1  number of independent S/R bits
// - CONFLICT  0  action per bit when S=1 and R=1 in the same cycle:
//                0 = reset wins (Q<=0), 1 = set wins (Q<=1), 2 = hold (Q unchanged)
// - INIT      0  per-bit value loaded into Q on reset (WIDTH-bit vector)
// PORTS
// - clk    in   1      rising-edge clock
// - rst    in   1      reset, synchronous, active-high
// - S      in   WIDTH  set request per bit
// - R      in   WIDTH  reset/clear request per bit
// - Q      out  WIDTH  stored state (registered)
// - Q_n    out  WIDTH  ~Q, always the exact complement of Q
// - err    out  1      only with LATCH_SR_ERR_EN; see CONFIGURATION
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is synchronous and active-high (rst). No asynchronous paths.
// - rst=1 at a rising edge: Q<=INIT and Q_n<=~INIT. S and R are ignored that cycle. Reset takes priority
//   over everything, including a mid-sequence conflict. With LATCH_SR_ERR_EN, err<=0.
// - rst=0, per bit i at each rising edge:
//     S=0 R=0 -> Q[i] held
//     S=1 R=0 -> Q[i]<=1
//     S=0 R=1 -> Q[i]<=0
//     S=1 R=1 -> Q[i] per CONFLICT (default 0: Q[i]<=0)
// - Latency: an S or R value sampled at edge n is visible on Q after edge n. Q is a pure register output.
// - Bits are independent. Simultaneous set on bit a and reset on bit b both take effect in the same cycle.
// - The S=R=1 to S=R=0 transition is deterministic: Q holds the value resolved by CONFLICT.
//   It never oscillates and never goes X.
// - Repeated S (or R) on an already-set (or already-cleared) bit: no change and no glitch.
// - Q_n is derived from the same register, so Q^Q_n is all-ones in every cycle.
// CONFIGURATION
// - Macro LATCH_SR_ERR_EN:
//   - Defined: adds output err. err<=1 (sticky) on any edge where rst=0 and some bit has S=1 and R=1.
//     Only rst clears it. Q behaviour is unchanged (CONFLICT still applies).
//   - Undefined: err port and its logic are absent.
// TESTING
// - Reset: rst=1 for 2 cycles with S=1 R=0, WIDTH=1 INIT=0 -> Q=0, Q_n=1 after each edge.
//   err=0 when LATCH_SR_ERR_EN is defined.
// - Set/hold: S=1 R=0 for 1 cycle, then S=0 R=0 for 3 cycles -> Q=1 from the first edge and stays 1.
// - Conflict: S=1 R=1 then S=0 R=0 -> Q=0 and held (CONFLICT=0).
//   Repeat with CONFLICT=1 -> Q=1; with CONFLICT=2 -> Q unchanged.
//   With LATCH_SR_ERR_EN, err=1 and stays 1 until rst.
// - Clear/hold: from Q=1, S=0 R=1 then S=0 R=0 -> Q=0 held. Then S=1 R=0, S=0 R=0 -> Q=1 held.
// - Multi-bit: WIDTH=4, Q=4'b0101, S=4'b1000 R=4'b0001 -> Q=4'b1100 and Q_n=4'b0011 after one edge.
// - Reset mid-operation: Q=1, assert rst with S=R=1 -> Q=INIT next edge. Release rst with S=R=0 -> Q holds INIT.

Source files
------------

// File: rtl/latch_sr.sv
// latch_sr: clocked set/reset storage, WIDTH independent bits.
// Each bit is set by S, cleared by R, and held when neither is asserted.
// CONFLICT chooses the S=R=1 outcome: 0 reset wins, 1 set wins, 2 hold.
// Optional feature macro: LATCH_SR_ERR_EN adds a sticky err output that
// flags any cycle in which some bit saw S=1 and R=1 together.
module latch_sr #(
  parameter int unsigned          WIDTH    = 1,
  parameter int unsigned          CONFLICT = 0,
  parameter logic [WIDTH-1:0]     INIT     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
`ifdef LATCH_SR_ERR_EN
  ,
  output logic             err
`endif
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_nxt;

  // Per-bit next value from the S/R pair, conflicts resolved by CONFLICT
  always_comb begin
    state_nxt = state;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case ({S[i], R[i]})
        2'b10:   state_nxt[i] = 1'b1;
        2'b01:   state_nxt[i] = 1'b0;
        2'b11: begin
          if (CONFLICT == 1)      state_nxt[i] = 1'b1;
          else if (CONFLICT == 2) state_nxt[i] = state[i];
          else                    state_nxt[i] = 1'b0;
        end
        default: state_nxt[i] = state[i];
      endcase
    end
  end

  // State register; reset overrides any pending set/clear request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Both outputs come from the one register, so they can never disagree
  assign Q   = state;
  assign Q_n = ~state;

`ifdef LATCH_SR_ERR_EN
  logic conflict_seen;

  // Any bit requesting set and clear at once
  always_comb begin
    conflict_seen = |(S & R);
  end

  // Sticky conflict flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (conflict_seen) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_latch_sr.sv
// tb_latch_sr: directed bench for latch_sr. Three 1-bit instances share
// stimulus (CONFLICT 0/1/2); a 4-bit instance with INIT=4'b0101 covers
// bit independence and non-zero reset values.
module tb_latch_sr;

  logic       clk;
  logic       rst;
  logic       s1, r1;
  logic [3:0] s4, r4;
  logic       q0, qn0, q1, qn1, q2, qn2;
  logic [3:0] q4, qn4;
`ifdef LATCH_SR_ERR_EN
  logic       e0, e1, e2, e4;
`endif

  int tests;
  int failed;

  latch_sr #(.WIDTH(1), .CONFLICT(0), .INIT(1'b0)) u_c0 (
    .clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q0), .Q_n(qn0)
`ifdef LATCH_SR_ERR_EN
    , .err(e0)
`endif
  );

  latch_sr #(.WIDTH(1), .CONFLICT(1), .INIT(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q1), .Q_n(qn1)
`ifdef LATCH_SR_ERR_EN
    , .err(e1)
`endif
  );

  latch_sr #(.WIDTH(1), .CONFLICT(2), .INIT(1'b0)) u_c2 (
    .clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q2), .Q_n(qn2)
`ifdef LATCH_SR_ERR_EN
    , .err(e2)
`endif
  );

  latch_sr #(.WIDTH(4), .CONFLICT(0), .INIT(4'b0101)) u_w4 (
    .clk(clk), .rst(rst), .S(s4), .R(r4), .Q(q4), .Q_n(qn4)
`ifdef LATCH_SR_ERR_EN
    , .err(e4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 1-bit instances: Q values plus complement integrity
  task automatic check1(input string tag, input logic e0v, input logic e1v, input logic e2v);
    check({tag, ".q0"}, {3'b0, q0}, {3'b0, e0v});
    check({tag, ".q1"}, {3'b0, q1}, {3'b0, e1v});
    check({tag, ".q2"}, {3'b0, q2}, {3'b0, e2v});
    check({tag, ".cmp"}, {1'b0, q0 ^ qn0, q1 ^ qn1, q2 ^ qn2}, 4'b0111);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst = 1'b1; s1 = 1'b1; r1 = 1'b0; s4 = 4'b1111; r4 = 4'b0000;

    // Reset held two cycles with S asserted
    step();
    check1("rst1", 1'b0, 1'b0, 1'b0);
    check("rst1.qn0", {3'b0, qn0}, 4'b0001);
    check("rst1.q4", q4, 4'b0101);
    check("rst1.qn4", qn4, 4'b1010);
`ifdef LATCH_SR_ERR_EN
    check("rst1.err", {e0, e1, e2, e4}, 4'b0000);
`endif
    step();
    check1("rst2", 1'b0, 1'b0, 1'b0);
    check("rst2.q4", q4, 4'b0101);

    // Set then hold three cycles
    rst = 1'b0; s1 = 1'b1; r1 = 1'b0; s4 = 4'b0000;
    step();
    check1("set", 1'b1, 1'b1, 1'b1);
    s1 = 1'b0;
    step(); check1("hold1", 1'b1, 1'b1, 1'b1);
    step(); check1("hold2", 1'b1, 1'b1, 1'b1);
    step(); check1("hold3", 1'b1, 1'b1, 1'b1);
    check("hold.q4", q4, 4'b0101);

    // Conflict from Q=1, then release
    s1 = 1'b1; r1 = 1'b1;
    step(); check1("conf_hi", 1'b0, 1'b1, 1'b1);
`ifdef LATCH_SR_ERR_EN
    check("conf_hi.err", {e0, e1, e2, e4}, 4'b1110);
`endif
    s1 = 1'b0; r1 = 1'b0;
    step(); check1("conf_hi_rel", 1'b0, 1'b1, 1'b1);

    // Clear all, then conflict from Q=0 so the hold case is distinguishable
    r1 = 1'b1;
    step(); check1("clr_all", 1'b0, 1'b0, 1'b0);
    s1 = 1'b1; r1 = 1'b1;
    step(); check1("conf_lo", 1'b0, 1'b1, 1'b0);
    s1 = 1'b0; r1 = 1'b0;
    step(); check1("conf_lo_rel", 1'b0, 1'b1, 1'b0);
`ifdef LATCH_SR_ERR_EN
    check("err_sticky", {e0, e1, e2, e4}, 4'b1110);
`endif

    // Set, clear, hold, set, hold
    s1 = 1'b1;
    step(); check1("cs_set", 1'b1, 1'b1, 1'b1);
    s1 = 1'b0; r1 = 1'b1;
    step(); check1("cs_clr", 1'b0, 1'b0, 1'b0);
    r1 = 1'b0;
    step(); check1("cs_hold0", 1'b0, 1'b0, 1'b0);
    s1 = 1'b1;
    step(); check1("cs_set2", 1'b1, 1'b1, 1'b1);
    s1 = 1'b0;
    step(); check1("cs_hold1", 1'b1, 1'b1, 1'b1);

    // Multi-bit: set bit 3 and clear bit 0 in one edge
    s4 = 4'b1000; r4 = 4'b0001;
    step();
    check("mb.q4", q4, 4'b1100);
    check("mb.qn4", qn4, 4'b0011);
    s4 = 4'b0000; r4 = 4'b0000;
    step();
    check("mb_hold.q4", q4, 4'b1100);
    // Repeated set on an already-set bit changes nothing
    s4 = 4'b0100;
    step();
    check("mb_reset_noop.q4", q4, 4'b1100);

    // Reset during a conflict
    s1 = 1'b1; r1 = 1'b1; s4 = 4'b1111; r4 = 4'b1111; rst = 1'b1;
    step();
    check1("mid_rst", 1'b0, 1'b0, 1'b0);
    check("mid_rst.q4", q4, 4'b0101);
`ifdef LATCH_SR_ERR_EN
    check("mid_rst.err", {e0, e1, e2, e4}, 4'b0000);
`endif
    rst = 1'b0; s1 = 1'b0; r1 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
    step();
    check1("post_rst", 1'b0, 1'b0, 1'b0);
    check("post_rst.q4", q4, 4'b0101);
    check("post_rst.qn4", qn4, 4'b1010);
`ifdef LATCH_SR_ERR_EN
    check("post_rst.err", {e0, e1, e2, e4}, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
